// File: rtl/dff_bank_arbiter_if.sv
// Bus bundle between the requesters and the shared-register write-port arbiter.
// The master side drives requests and data; the slave side (arbiter) returns grant and register state.
interface dff_bank_arbiter_if #(
    parameter int unsigned N = 4,
    parameter int unsigned W = 8
);
    localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]   req;
    logic [N*W-1:0] wdata;
    logic [N-1:0]   gnt;
    logic [OW-1:0]  owner;
    logic           busy;
    logic [W-1:0]   q;
    logic [W-1:0]   q_n;

    modport master (
        output req, wdata,
        input  gnt, owner, busy, q, q_n
    );

    modport slave (
        input  req, wdata,
        output gnt, owner, busy, q, q_n
    );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter owning the D/enable path of one shared W-bit register.
// A bounded hold count lets a waiting requester preempt a long-running owner.
module dff_bank_arbiter #(
    parameter int unsigned N        = 4,
    parameter int unsigned W        = 8,
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic                clk,
    input  logic                clr,
    dff_bank_arbiter_if.slave   bus
);
    localparam int unsigned OW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q,   gnt_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic            busy_q,  busy_d;
    logic [OW-1:0]   ptr_q,   ptr_d;
    logic [HW-1:0]   hold_q,  hold_d;
    logic [W-1:0]    q_q,     q_d;

    logic            sel_valid;
    logic [OW-1:0]   sel_idx;
    logic [OW-1:0]   sel_ptr_nxt;
    logic [W-1:0]    own_data;
    logic            others_waiting;

    // Rotating priority search: first asserted request at or after the pointer.
    always_comb begin
        int unsigned cand;
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(ptr_q) + i) % N;
            if (!sel_valid && bus.req[cand]) begin
                sel_valid = 1'b1;
                sel_idx   = OW'(cand);
            end
        end
        sel_ptr_nxt = OW'((32'(sel_idx) + 32'd1) % N);
    end

    // Current owner's write slice, muxed with constant part-selects.
    always_comb begin
        own_data = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (OW'(i) == owner_q) begin
                own_data = bus.wdata[i*W +: W];
            end
        end
    end

    assign others_waiting = |(bus.req & ~gnt_q);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            busy_q  <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
            q_q     <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            busy_q  <= busy_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            q_q     <= q_d;
        end
    end

    always_comb begin
        logic grant_new;
        state_d   = state_q;
        gnt_d     = gnt_q;
        owner_d   = owner_q;
        busy_d    = busy_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        q_d       = q_q;
        grant_new = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    grant_new = 1'b1;
                end
            end
            ST_OWN: begin
                if (!bus.req[owner_q]) begin
                    // Release: owner's request is low, so the search cannot pick it again.
                    if (sel_valid) begin
                        grant_new = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                        owner_d = '0;
                        busy_d  = 1'b0;
                        hold_d  = '0;
                    end
                end else if ((hold_q == HW'(MAX_HOLD)) && others_waiting) begin
                    // Preempt after a final write; pointer already ranks the owner last.
                    q_d       = own_data;
                    grant_new = 1'b1;
                end else begin
                    q_d = own_data;
                    if (hold_q < HW'(MAX_HOLD)) begin
                        hold_d = hold_q + HW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (grant_new) begin
            state_d = ST_OWN;
            gnt_d   = N'(1) << sel_idx;
            owner_d = sel_idx;
            busy_d  = 1'b1;
            hold_d  = HW'(1);
            ptr_d   = sel_ptr_nxt;
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.owner = owner_q;
    assign bus.busy  = busy_q;
    assign bus.q     = q_q;
    assign bus.q_n   = ~q_q;

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin write-port arbiter for one shared W-bit storage register built from D flip-flops.
- Up to N requesters compete for the register's single write port.
- The block owns the register's D/enable path and sequences which requester loads it each cycle.
- It enforces a bounded hold time, so one requester cannot starve the others.

Parameters:
- N, 4, number of requesters (>=1).
- W, 8, storage register width.
- MAX_HOLD, 4, maximum consecutive granted cycles when others are waiting (>=1).

Ports:
- clk  input  1  rising-edge clock.
- clr  input  1  asynchronous active-low reset.
- req  input  N  per-requester write request; bit i is held high while requester i wants the port.
- wdata  input  N*W  per-requester write data; requester i's data is wdata[i*W +: W].
- gnt  output  N  registered one-hot grant; all zero when idle.
- owner  output  clog2(N) (min 1)  index of the granted requester; 0 when idle.
- busy  output  1  high when any gnt bit is high.
- q  output  W  shared storage register value.
- q_n  output  W  bitwise complement of q, combinational.

Behaviour:
- Reset (clr low, takes effect without a clock edge):
  - gnt=0, owner=0, busy=0, q=0, q_n=all ones.
  - Round-robin pointer=0; hold_cnt=0; state IDLE.
- States: IDLE (no grant) and OWN (gnt[k]=1 for exactly one k).
- Selection: the first requester with req high, searching from the pointer upward and wrapping modulo N.
- In IDLE, at an edge where req!=0:
  - gnt <= one-hot(selected); owner <= selected; hold_cnt <= 1; state <= OWN.
  - No write to q at this edge.
- In IDLE with req=0: outputs unchanged.
- In OWN with owner k, at each edge the first matching rule applies:
  - a) req[k]=0: release. No write.
    - If any other req is high: grant the next selected requester at this same edge (no idle bubble); hold_cnt <= 1.
    - Otherwise go to IDLE; gnt <= 0.
  - b) req[k]=1, hold_cnt==MAX_HOLD, and another req is high: preempt.
    - q <= wdata slice k (final write).
    - Grant moves to the next selected requester; hold_cnt <= 1.
  - c) req[k]=1 otherwise:
    - q <= wdata slice k; grant unchanged.
    - hold_cnt increments, saturating at MAX_HOLD.
- Pointer:
  - Whenever a new grant to requester j is issued, pointer <= (j+1) mod N.
  - The released or preempted owner therefore has lowest priority for the next selection.
- Latency:
  - req rises before edge E0: gnt visible after E0.
  - The first write uses wdata sampled at E1, so q is updated after E1.
- q changes only on a write edge (a grant-holding cycle with req high); otherwise q holds.
- A sole requester keeps the grant indefinitely; hold_cnt saturates and q updates every cycle.
- N=1: preemption never occurs; the pointer is always 0.
- req bits of non-owners never affect q.
- Reset asserted mid-grant: immediate return to the reset values above; any write in progress is lost.
- Reset deasserted: first possible grant at the first rising edge with clr high.

Test Plan:
- Async reset: with gnt=4'b0010 and q=8'h3C, pull clr low between edges -> gnt=0, busy=0, q=8'h00, q_n=8'hFF immediately, no clock needed.
- Single requester: req=4'b0100, wdata slice 2=8'hA5 -> gnt=4'b0100, owner=2 after edge 1; q=8'hA5 after edge 2.
- Hold limit with MAX_HOLD=4, req=4'b1111 held, slice i data=8'h10+i:
  - gnt sequence: 0001 x4 cycles, 0010 x4, 0100 x4, 1000 x4, back to 0001.
  - q follows 8'h10, 8'h11, 8'h12, 8'h13 with one-edge lag.
- Release handover: owner 0 drops req0 while req3 is high -> gnt goes 0001 -> 1000 at the same edge, busy stays 1, q unchanged at that edge.
- Pointer wrap: owner 3 releases while req0 and req2 are high -> gnt=0001 next; after owner 0 releases, gnt=0100.
- Sole long holder: req=4'b0010 for 10 cycles with data incrementing each cycle -> gnt stays 0010 throughout, q updates every edge, no preemption.
